// File: rtl/kgp_ctrl_defs.sv
// kgp_ctrl_defs: shared opcode, func, ALU, branch, write-back and state encodings for control_fsm and data_path
package kgp_ctrl_defs;
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_ADDI   = 6'b000001;
  localparam logic [5:0] OP_COMPI  = 6'b000010;
  localparam logic [5:0] OP_LW     = 6'b000011;
  localparam logic [5:0] OP_SW     = 6'b000100;
  localparam logic [5:0] OP_BRANCH = 6'b000101;
  localparam logic [5:0] OP_HALT   = 6'b111111;
  localparam logic [5:0] FUNC_MAX  = 6'b001001;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_COMP  = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SHLL  = 4'b0100;
  localparam logic [3:0] ALU_SHRL  = 4'b0101;
  localparam logic [3:0] ALU_SHLLV = 4'b0110;
  localparam logic [3:0] ALU_SHRLV = 4'b0111;
  localparam logic [3:0] ALU_SHRA  = 4'b1000;
  localparam logic [3:0] ALU_SHRAV = 4'b1001;
  localparam logic [4:0] BR_NONE   = 5'b00000;
  localparam logic [4:0] BR_B      = 5'b00001;
  localparam logic [4:0] BR_BR     = 5'b00010;
  localparam logic [4:0] BR_BLTZ   = 5'b00011;
  localparam logic [4:0] BR_BZ     = 5'b00100;
  localparam logic [4:0] BR_BNZ    = 5'b00101;
  localparam logic [4:0] BR_BL     = 5'b00110;
  localparam logic [4:0] BR_BCY    = 5'b00111;
  localparam logic [4:0] BR_BNCY   = 5'b01000;
  localparam logic [1:0] RW_NONE   = 2'b00;
  localparam logic [1:0] RW_RS     = 2'b01;
  localparam logic [1:0] RW_RT     = 2'b10;
  localparam logic [1:0] RW_LINK   = 2'b11;
  localparam logic [1:0] RWM_PC1   = 2'b00;
  localparam logic [1:0] RWM_DMEM  = 2'b01;
  localparam logic [1:0] RWM_ALU   = 2'b10;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BR, C_HALT, C_ILL} instr_class_e;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: latched opcode/func to instruction class, alu_op, br_op and immediate-operand select
module instr_decoder
  import kgp_ctrl_defs::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   func,
  output instr_class_e cls,
  output logic [3:0]   alu_op,
  output logic [4:0]   br_op,
  output logic         use_imm
);
  logic br_ok;
  assign br_ok = func[4:0] >= BR_B && func[4:0] <= BR_BNCY;
  always_comb begin
    cls = C_ILL;
    alu_op = ALU_ADD;
    br_op = BR_NONE;
    use_imm = 1'b0;
    case (opcode)
      OP_RTYPE: if (func <= FUNC_MAX) begin
        cls = C_ALU;
        alu_op = func[3:0];
      end
      OP_ADDI: begin
        cls = C_ALU;
        use_imm = 1'b1;
      end
      OP_COMPI: begin
        cls = C_ALU;
        alu_op = ALU_COMP;
        use_imm = 1'b1;
      end
      OP_LW: cls = C_LW;
      OP_SW: cls = C_SW;
      OP_BRANCH: if (br_ok) begin
        cls = C_BR;
        br_op = func[4:0];
      end
      OP_HALT: cls = C_HALT;
      default: ;
    endcase
  end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the KGP-miniRISC data_path
// Outputs decode only from state and the opcode/func copy latched in DECODE.
module control_fsm
  import kgp_ctrl_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  output logic             ir_en,
  output logic             pc_en,
  output logic [1:0]       reg_write,
  output logic             imm_mux_ctrl,
  output logic             alu_mux_ctrl,
  output logic [3:0]       alu_op,
  output logic             dmem_enable,
  output logic             dmem_write_enable,
  output logic [1:0]       reg_write_mux_ctrl,
  output logic [4:0]       br_op,
  output logic             illegal_instr,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  state_e       state, next;
  instr_class_e cls;
  logic         live, use_imm;
  logic [5:0]   op_q, fn_q;
  logic [3:0]   dec_alu;
  logic [4:0]   dec_br;
  instr_decoder u_dec (
    .opcode (op_q),
    .func   (fn_q),
    .cls    (cls),
    .alu_op (dec_alu),
    .br_op  (dec_br),
    .use_imm(use_imm)
  );
  // live holds every output low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      live <= 1'b0;
      op_q <= '0;
      fn_q <= '0;
      retired <= '0;
    end else begin
      live <= 1'b1;
      state <= next;
      if (state == S_DECODE) begin
        op_q <= opcode;
        fn_q <= func;
      end
      if (pc_en) retired <= retired + CNT_W'(1);
    end
  end
  always_comb begin
    ir_en = 1'b0;
    pc_en = 1'b0;
    reg_write = RW_NONE;
    imm_mux_ctrl = 1'b0;
    alu_mux_ctrl = 1'b0;
    alu_op = ALU_ADD;
    dmem_enable = 1'b0;
    dmem_write_enable = 1'b0;
    reg_write_mux_ctrl = RWM_PC1;
    br_op = BR_NONE;
    illegal_instr = 1'b0;
    halted = 1'b0;
    next = state;
    if (live) case (state)
      S_FETCH: begin
        ir_en = 1'b1;
        next = S_DECODE;
      end
      S_DECODE: next = S_EXEC;
      S_EXEC: case (cls)
        C_ALU: begin
          alu_op = dec_alu;
          alu_mux_ctrl = use_imm;
          reg_write = RW_RS;
          reg_write_mux_ctrl = RWM_ALU;
          pc_en = 1'b1;
          next = S_FETCH;
        end
        C_LW, C_SW: begin
          imm_mux_ctrl = 1'b1;
          alu_mux_ctrl = 1'b1;
          next = S_MEM;
        end
        C_BR: begin
          br_op = dec_br;
          reg_write = dec_br == BR_BL ? RW_LINK : RW_NONE;
          pc_en = 1'b1;
          next = S_FETCH;
        end
        C_HALT: next = S_HALT;
        default: begin
          illegal_instr = 1'b1;
          pc_en = 1'b1;
          next = S_FETCH;
        end
      endcase
      S_MEM: begin
        imm_mux_ctrl = 1'b1;
        alu_mux_ctrl = 1'b1;
        dmem_enable = 1'b1;
        dmem_write_enable = cls == C_SW;
        pc_en = cls == C_SW;
        next = cls == C_SW ? S_FETCH : S_WB;
      end
      S_WB: begin
        imm_mux_ctrl = 1'b1;
        alu_mux_ctrl = 1'b1;
        dmem_enable = 1'b1;
        reg_write = RW_RT;
        reg_write_mux_ctrl = RWM_DMEM;
        pc_en = 1'b1;
        next = S_FETCH;
      end
      default: halted = 1'b1;
    endcase
  end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the KGP-miniRISC core, sitting directly upstream of `data_path`. It consumes `opcode_out`/`func_out` from `data_path` and drives every `data_path` control input (`reg_write`, `imm_mux_ctrl`, `alu_mux_ctrl`, `alu_op`, `dmem_enable`, `dmem_write_enable`, `reg_write_mux_ctrl`, `br_op`) plus PC/IR load enables. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and retires it.

## Interface
Parameters:
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `opcode` in 6: from `data_path.opcode_out`
- `func` in 6: from `data_path.func_out`
- `ir_en` out 1: load instruction register
- `pc_en` out 1: advance/update PC (branch target when `br_op`≠0)
- `reg_write` out 2: 00 none, 01 write rs (ALU dest), 10 write rt (load dest), 11 write $31 (link)
- `imm_mux_ctrl` out 1: 0 = 16-bit ALU immediate, 1 = load/store offset
- `alu_mux_ctrl` out 1: 0 = register operand, 1 = immediate operand
- `alu_op` out 4: 0000 add, 0001 comp, 0010 and, 0011 xor, 0100 shll, 0101 shrl, 0110 shllv, 0111 shrlv, 1000 shra, 1001 shrav
- `dmem_enable`, `dmem_write_enable` out 1 each
- `reg_write_mux_ctrl` out 2: 00 PC+1, 01 dmem, 10 ALU
- `br_op` out 5: 00000 none, 00001 b, 00010 br, 00011 bltz, 00100 bz, 00101 bnz, 00110 bl, 00111 bcy, 01000 bncy
- `illegal_instr` out 1: one-cycle pulse on undefined opcode/func
- `halted` out 1: level, core stopped
- `retired` out `CNT_W`: count of completed instructions

## Operation
- Opcode map: 000000 R-type (func 000000–001001 selects `alu_op` in listed order); 000001 addi; 000010 compi; 000011 lw; 000100 sw; 000101 branch (func[4:0] = `br_op` code, 00001–01000); 111111 halt. Anything else is illegal.
- States: FETCH → DECODE → EXEC → {FETCH | MEM}; MEM → {FETCH | WB}; WB → FETCH; HALT absorbing.
- FETCH: `ir_en`=1, all else 0.
- DECODE: latch `opcode`/`func` into internal registers. All later outputs decode from the latched copy only; no combinational path from inputs to outputs.
- EXEC:
  - R-type/addi/compi: ALU controls, `reg_write`=01, `reg_write_mux_ctrl`=10, `pc_en`=1, then → FETCH.
  - lw/sw: `imm_mux_ctrl`=1, `alu_mux_ctrl`=1, `alu_op`=0000, then → MEM.
  - branch: `br_op` driven, `pc_en`=1. `bl` also sets `reg_write`=11 and `reg_write_mux_ctrl`=00. Then → FETCH.
  - halt: → HALT.
  - illegal: `illegal_instr`=1, `pc_en`=1 (executes as NOP), then → FETCH.
- MEM: address controls held. `dmem_enable`=1.
  - sw: `dmem_write_enable`=1, `pc_en`=1, then → FETCH.
  - lw: → WB.
- WB (lw): `dmem_enable`=1, `reg_write`=10, `reg_write_mux_ctrl`=01, `pc_en`=1, then → FETCH.
- `retired` increments in the cycle `pc_en`=1. Halt does not count; illegal does count. Counter wraps modulo 2^`CNT_W`.
- HALT: all outputs 0 except `halted`=1. Exit only via reset.

## Timing
- Reset (`rst`=0, async): state=FETCH, latched opcode/func=0, `retired`=0, all outputs 0.
- First FETCH asserts `ir_en` in the first cycle after `rst` deasserts. Reset mid-instruction aborts with no write.
- Cycles per instruction: ALU/branch/illegal 3, sw 4, lw 5, halt 3 to reach HALT.
- `reg_write` and `dmem_write_enable` are high for exactly one cycle per instruction, never both in the same cycle.
- `opcode`/`func` are sampled only in DECODE. Changes in any other state are ignored.

## Structure
- Shared package `kgp_ctrl_defs`: opcode, func, `alu_op`, `br_op`, `reg_write`/`reg_write_mux_ctrl` encodings, and state encoding. `data_path` uses the same constants.
- One sub-module, `instr_decoder` (combinational): latched opcode/func → instruction class, `alu_op`, `br_op`, illegal.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with opcode=000000 → all outputs 0, `retired`=0. After release, `ir_en`=1 on the first edge.
- xor (opcode 000000, func 000011) → EXEC cycle 3 shows `alu_op`=0011, `reg_write`=01, `reg_write_mux_ctrl`=10, `pc_en`=1; `retired`=1.
- sw then lw (000100, 000011):
  - sw: `dmem_write_enable` one cycle in cycle 4, `reg_write`=00 throughout.
  - lw: `reg_write`=10 and `reg_write_mux_ctrl`=01 in cycle 5.
  - After both, `retired`=2.
- bl (000101, func 00110) → `br_op`=00110, `reg_write`=11, `reg_write_mux_ctrl`=00 in EXEC.
- Illegal opcode 101010 → `illegal_instr` pulses one cycle, then FETCH. Halt 111111 → `halted`=1 and stays high across 10 further cycles; `retired` is unchanged.
- Reset asserted during lw MEM state → outputs 0 immediately and `reg_write` never reaches 10.
